// File: rtl/mux_nch_pkg.sv
// Shared types and limits for the N-channel registered mux.
package mux_nch_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned N_CH_MAX = 16;

endpackage

// File: rtl/mux_nch_rr_if.sv
// Handshake bundle between channel drivers, the mux and its consumer.
interface mux_nch_rr_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) ();
  import mux_nch_pkg::*;

  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  mode_e             mode;
  logic [SEL_W-1:0]  sel;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first asserted request at or above ptr_i, wrapping.
module rr_arbiter_n #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         req_i,
  input  logic [$clog2(N_CH)-1:0] ptr_i,
  output logic [$clog2(N_CH)-1:0] gnt_idx_o,
  output logic                    gnt_valid_o
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  int unsigned idx;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      // Explicit wrap so non-power-of-two channel counts stay in range.
      idx = 32'(ptr_i) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_idx_o   = SEL_W'(idx);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nch_rr.sv
// N-channel W-bit mux with registered output, fixed-select or round-robin grant.
// Define MUX_NCH_SEL_ERR_EN to add the sel_err flag and saturating err_cnt ports.
module mux_nch_rr
  import mux_nch_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nch_rr_if.slave  bus
`ifdef MUX_NCH_SEL_ERR_EN
  ,
  output logic         sel_err,
  output logic [7:0]   err_cnt
`endif
);

  localparam int unsigned SEL_W = $clog2(N_CH);

  if (N_CH < 2 || N_CH > N_CH_MAX) begin : g_bad_nch
    $error("mux_nch_rr: N_CH out of range");
  end

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             sel_ok;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             xfer;
  logic [N_CH-1:0]  in_ready;

  rr_arbiter_n #(
    .N_CH (N_CH)
  ) u_arb (
    .req_i       (bus.in_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  always_comb begin
    load_en   = !out_valid_q || bus.out_ready;
    sel_ok    = 32'(bus.sel) < N_CH;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (bus.mode == MODE_RR) begin
      gnt_idx   = rr_idx;
      gnt_valid = rr_valid;
    end else if (sel_ok) begin
      gnt_idx   = bus.sel;
      gnt_valid = bus.in_valid[bus.sel];
    end
    // No handshake may complete while reset is asserted.
    xfer     = rst_n && load_en && gnt_valid;
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = bus.in_data[gnt_idx*W +: W];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (bus.mode == MODE_RR) begin
        rr_ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

`ifdef MUX_NCH_SEL_ERR_EN
  logic       sel_err_q, sel_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    sel_err_d = (bus.mode == MODE_FIXED) && !sel_ok;
    err_cnt_d = err_cnt_q;
    if (sel_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign sel_err = sel_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nch_rr.sv
// Directed bench for mux_nch_rr: reset, fixed select, round-robin, backpressure, mid reset.
module tb_mux_nch_rr;
  import mux_nch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_nch_rr_if #(.N_CH(4), .W(8)) bus ();

`ifdef MUX_NCH_SEL_ERR_EN
  logic       m_sel_err;
  logic [7:0] m_err_cnt;
  logic       e_sel_err;
  logic [7:0] e_err_cnt;

  mux_nch_rr_if #(.N_CH(3), .W(8)) ebus ();

  mux_nch_rr #(.N_CH(3), .W(8)) u_dut_err (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ebus),
    .sel_err (e_sel_err),
    .err_cnt (e_err_cnt)
  );
`endif

  mux_nch_rr #(.N_CH(4), .W(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef MUX_NCH_SEL_ERR_EN
    ,
    .sel_err (m_sel_err),
    .err_cnt (m_err_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] chan_data(input int ch);
    return 8'(8'h11 * (ch + 1));
  endfunction

  initial begin
    int sp_ch[4];
    sp_ch = '{1, 3, 1, 3};

    rst_n         = 1'b0;
    bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.in_valid  = 4'b1111;
    bus.mode      = MODE_FIXED;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
`ifdef MUX_NCH_SEL_ERR_EN
    ebus.in_data   = {8'hC3, 8'hB2, 8'hA1};
    ebus.in_valid  = 3'b000;
    ebus.mode      = MODE_FIXED;
    ebus.sel       = 2'd0;
    ebus.out_ready = 1'b1;
`endif

    repeat (2) tick();
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'b0000);

    // Fixed select of channel 2.
    rst_n   = 1'b1;
    bus.sel = 2'd2;
    #1;
    check_eq("fix_in_ready0", 32'(bus.in_ready), 32'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("fix_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("fix_out_data", 32'(bus.out_data), 32'h33);
      check_eq("fix_out_ch", 32'(bus.out_ch), 32'd2);
      check_eq("fix_in_ready", 32'(bus.in_ready), 32'b0100);
    end

    // Round-robin, all channels requesting; pointer still 0 after fixed mode.
    bus.mode = MODE_RR;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("rr_out_ch", 32'(bus.out_ch), 32'(i % 4));
      check_eq("rr_out_data", 32'(bus.out_data), 32'(chan_data(i % 4)));
    end

    // Sparse round-robin on channels 1 and 3.
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("sp_out_ch", 32'(bus.out_ch), 32'(sp_ch[i]));
      check_eq("sp_out_data", 32'(bus.out_data), 32'(chan_data(sp_ch[i])));
    end
    bus.in_valid = 4'b0000;
    tick();
    check_eq("sp_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure with a held word.
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    #1;
    check_eq("bp_in_ready_empty", 32'(bus.in_ready), 32'b0001);
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_out_ch", 32'(bus.out_ch), 32'd0);
      check_eq("bp_out_data", 32'(bus.out_data), 32'h11);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'b0000);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    check_eq("bp_next_ch", 32'(bus.out_ch), 32'd1);
    check_eq("bp_next_data", 32'(bus.out_data), 32'h22);

    // Mid-operation reset drops the held word and rewinds the pointer.
    rst_n = 1'b0;
    #1;
    check_eq("mr_in_ready", 32'(bus.in_ready), 32'b0000);
    tick();
    check_eq("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mr_out_ch", 32'(bus.out_ch), 32'd0);
    check_eq("mr_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("mr_ptr_zero", 32'(bus.in_ready), 32'b0001);
    tick();
    check_eq("mr_first_ch", 32'(bus.out_ch), 32'd0);
    check_eq("mr_first_valid", 32'(bus.out_valid), 32'd1);

`ifdef MUX_NCH_SEL_ERR_EN
    check_eq("err_cnt_init", 32'(e_err_cnt), 32'd0);
    ebus.in_valid = 3'b111;
    ebus.sel      = 2'd3;
    #1;
    check_eq("err_in_ready", 32'(ebus.in_ready), 32'b000);
    tick();
    check_eq("err_sel_err", 32'(e_sel_err), 32'd1);
    check_eq("err_cnt_one", 32'(e_err_cnt), 32'd1);
    check_eq("err_no_xfer", 32'(ebus.out_valid), 32'd0);
    ebus.sel = 2'd1;
    tick();
    check_eq("err_sel_clear", 32'(e_sel_err), 32'd0);
    check_eq("err_cnt_hold", 32'(e_err_cnt), 32'd1);
    check_eq("err_ok_data", 32'(ebus.out_data), 32'hA1 + 32'h11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
